// File: rtl/engine_stride_index_sequencer_pkg.sv
// Shared types for the stride index sequencer: configuration, response beat and
// generator FSM states, plus the granularity-to-chunk-limit helper.
package engine_stride_index_sequencer_pkg;

   localparam int M_AXI_MEMORY_ADDR_WIDTH = 32;
   localparam int ADDR_W                  = M_AXI_MEMORY_ADDR_WIDTH;
   localparam int CHUNK_CNT_W             = 16;
   localparam int CHUNK_MAX               = (1 << CHUNK_CNT_W) - 1;

   typedef enum logic [3:0] {
      RESET,
      IDLE,
      SETUP,
      START,
      BUSY_TRANS,
      BUSY,
      PAUSE_TRANS,
      PAUSE,
      DONE
   } engine_stride_index_generator_state;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] kind;
   } MemoryPacketMeta;

   typedef struct packed {
      logic [ADDR_W-1:0] index_start;
      logic [ADDR_W-1:0] index_end;
      logic [ADDR_W-1:0] stride;
      logic [ADDR_W-1:0] granularity;
      logic              increment;
      logic              decrement;
   } StrideIndexParam;

   typedef struct packed {
      logic            valid;
      StrideIndexParam param;
      MemoryPacketMeta meta;
   } StrideIndexConfiguration;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] index;
      logic              last;
      logic              final_beat;
      MemoryPacketMeta   meta;
   } StrideIndexResponse;

   // Chunk counter terminal value: max(min(granularity, CHUNK_MAX), 1) - 1.
   function automatic logic [CHUNK_CNT_W-1:0] chunk_limit(input logic [ADDR_W-1:0] granularity);
      logic [ADDR_W-1:0] sat;
      sat = (granularity > ADDR_W'(CHUNK_MAX)) ? ADDR_W'(CHUNK_MAX) : granularity;
      if (sat == '0) begin
         sat = ADDR_W'(1);
      end
      return CHUNK_CNT_W'(sat - ADDR_W'(1));
   endfunction

endpackage

// File: rtl/engine_stride_index_sequencer_if.sv
// Response channel from the sequencer to the read/write engine (valid/ready).
interface engine_stride_index_sequencer_if;
   import engine_stride_index_sequencer_pkg::*;

   StrideIndexResponse response_out;
   logic               response_out_ready;

   modport master (output response_out, input response_out_ready);
   modport slave  (input response_out, output response_out_ready);
endinterface

// File: rtl/engine_stride_index_sequencer_output_reg.sv
// One-entry valid/ready holding register: a loaded beat stays put until accepted.
module engine_stride_index_output_reg
   import engine_stride_index_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  StrideIndexResponse i_beat,
   input  logic               i_ready,
   output StrideIndexResponse o_resp,
   output logic               o_accept,
   output logic               o_free
);

   StrideIndexResponse r_resp;

   // NOTE: the whole beat is in the async reset so a held beat is discarded and valid drops immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp <= '0;
      end else if (i_load) begin
         r_resp <= i_beat;
      end else if (o_accept) begin
         r_resp.valid <= 1'b0;
      end
   end

   assign o_resp   = r_resp;
   assign o_accept = r_resp.valid & i_ready;
   assign o_free   = ~r_resp.valid | i_ready;

endmodule

// File: rtl/engine_stride_index_sequencer.sv
// Turns one latched stride configuration into a registered stream of tagged indices,
// with pause/resume and carry/borrow-safe termination.
module engine_stride_index_sequencer
   import engine_stride_index_sequencer_pkg::*;
(
   input  logic                                   ap_clk,
   input  logic                                   areset_n,
   input  StrideIndexConfiguration                configuration_in,
   input  logic                                   start_in,
   input  logic                                   pause_in,
   engine_stride_index_sequencer_if.master        response_if,
   output logic                                   busy_out,
   output logic                                   done_out,
   output logic                                   config_error_out
);

   engine_stride_index_generator_state r_state, w_state_next;

   StrideIndexParam         r_param;
   MemoryPacketMeta         r_meta;
   logic [ADDR_W-1:0]       r_idx;
   logic                    r_more;
   logic [CHUNK_CNT_W-1:0]  r_chunk;
   logic [CHUNK_CNT_W-1:0]  r_chunk_max;
   logic                    r_cfg_err;

   logic [ADDR_W:0]         w_next_wide;
   logic [ADDR_W-1:0]       w_next;
   logic                    w_final;
   logic                    w_last;
   logic                    w_hold;
   logic                    w_load;
   logic                    w_accept;
   logic                    w_free;
   logic                    w_illegal;
   logic                    w_empty;
   logic                    w_active;
   StrideIndexResponse      w_beat;
   StrideIndexResponse      w_resp;

   assign w_illegal = (r_param.increment == r_param.decrement) || (r_param.stride == '0);
   assign w_empty   = r_param.increment ? (r_param.index_start >= r_param.index_end)
                                        : (r_param.index_start <= r_param.index_end);

   // One extra bit catches a carry (inc) or borrow (dec) so the sequence ends instead of wrapping.
   assign w_next_wide = r_param.increment ? ({1'b0, r_idx} + {1'b0, r_param.stride})
                                          : ({1'b0, r_idx} - {1'b0, r_param.stride});
   assign w_next      = w_next_wide[ADDR_W-1:0];
   assign w_final     = w_next_wide[ADDR_W] ||
                        (r_param.increment ? (w_next >= r_param.index_end)
                                           : (w_next <= r_param.index_end));
   assign w_last      = w_final || (r_chunk == r_chunk_max);

   // Dropping start_in mid-run is treated exactly like a pause request.
   assign w_hold   = pause_in | ~start_in;
   assign w_load   = (r_state == BUSY) && !w_hold && r_more && w_free;
   assign w_active = (r_state == BUSY_TRANS) || (r_state == BUSY) ||
                     (r_state == PAUSE_TRANS) || (r_state == PAUSE);

   always_comb begin
      w_beat            = '0;
      w_beat.valid      = 1'b1;
      w_beat.index      = r_idx;
      w_beat.last       = w_last;
      w_beat.final_beat = w_final;
      w_beat.meta       = r_meta;
   end

   engine_stride_index_output_reg u_out_reg (
      .clk      (ap_clk),
      .rst_n    (areset_n),
      .i_load   (w_load),
      .i_beat   (w_beat),
      .i_ready  (response_if.response_out_ready),
      .o_resp   (w_resp),
      .o_accept (w_accept),
      .o_free   (w_free)
   );

   assign response_if.response_out = w_resp;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RESET:       w_state_next = IDLE;
         IDLE:        if (configuration_in.valid) w_state_next = SETUP;
         SETUP:       w_state_next = START;
         START:       if (start_in) w_state_next = r_more ? BUSY_TRANS : DONE;
         BUSY_TRANS:  w_state_next = BUSY;
         BUSY:        if (w_hold) w_state_next = PAUSE_TRANS;
         PAUSE_TRANS: w_state_next = PAUSE;
         PAUSE:       if (!w_hold) w_state_next = BUSY_TRANS;
         DONE:        if (!start_in) w_state_next = IDLE;
         default:     w_state_next = IDLE;
      endcase
      // Acceptance of the final beat completes the run even if a pause is requested.
      if (w_active && w_accept && w_resp.final_beat) begin
         w_state_next = DONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         r_state     <= RESET;
         r_param     <= '0;
         r_meta      <= '0;
         r_idx       <= '0;
         r_more      <= 1'b0;
         r_chunk     <= '0;
         r_chunk_max <= '0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == IDLE) && configuration_in.valid) begin
            r_param <= configuration_in.param;
            r_meta  <= configuration_in.meta;
         end
         if (r_state == SETUP) begin
            r_idx       <= r_param.index_start;
            r_chunk     <= '0;
            r_chunk_max <= chunk_limit(r_param.granularity);
            r_more      <= !w_illegal && !w_empty;
            r_cfg_err   <= w_illegal;
         end else if (w_load) begin
            r_idx   <= w_next;
            r_chunk <= w_last ? '0 : r_chunk + 1'b1;
            r_more  <= !w_final;
         end
      end
   end

   assign busy_out         = w_active;
   assign done_out         = (r_state == DONE);
   assign config_error_out = r_cfg_err;

endmodule

// File: tb/tb_engine_stride_index_sequencer.sv
// Directed and randomized bench for the stride index sequencer, checked against a
// list-based model of the index range.
module tb_engine_stride_index_sequencer;
   import engine_stride_index_sequencer_pkg::*;

   logic                    ap_clk = 1'b0;
   logic                    areset_n;
   StrideIndexConfiguration configuration_in;
   logic                    start_in;
   logic                    pause_in;
   logic                    busy_out;
   logic                    done_out;
   logic                    config_error_out;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] index;
      bit          last;
      bit          fin;
   } exp_beat_t;

   exp_beat_t exp_q[$];

   engine_stride_index_sequencer_if u_if ();

   engine_stride_index_sequencer u_dut (
      .ap_clk           (ap_clk),
      .areset_n         (areset_n),
      .configuration_in (configuration_in),
      .start_in         (start_in),
      .pause_in         (pause_in),
      .response_if      (u_if),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .config_error_out (config_error_out)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   // Reference: enumerate the range with wide arithmetic, then tag chunk/final flags by position.
   task automatic build_expected(input bit inc, input bit dec, input logic [31:0] s,
                                 input logic [31:0] e, input logic [31:0] st, input logic [31:0] g);
      longint    v;
      longint    lim;
      longint    dv;
      int        gsat;
      int        n;
      exp_beat_t b;
      exp_q.delete();
      if (inc == dec || st == 0) return;
      v   = {32'h0, s};
      lim = {32'h0, e};
      dv  = {32'h0, st};
      while ((inc ? (v < lim) : (v > lim)) && exp_q.size() < 5000) begin
         b.index = v[31:0];
         b.last  = 1'b0;
         b.fin   = 1'b0;
         exp_q.push_back(b);
         v = inc ? v + dv : v - dv;
      end
      gsat = (g == 0) ? 1 : ((g > 65535) ? 65535 : int'(g));
      n    = exp_q.size();
      foreach (exp_q[k]) begin
         exp_q[k].last = (((k + 1) % gsat) == 0) || (k == n - 1);
         exp_q[k].fin  = (k == n - 1);
      end
   endtask

   task automatic load_config(input bit inc, input bit dec, input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] st, input logic [31:0] g, input MemoryPacketMeta meta);
      start_in                       = 1'b0;
      pause_in                       = 1'b0;
      u_if.response_out_ready        = 1'b0;
      configuration_in               = '0;
      step();
      step();
      configuration_in.valid             = 1'b1;
      configuration_in.param.increment   = inc;
      configuration_in.param.decrement   = dec;
      configuration_in.param.index_start = s;
      configuration_in.param.index_end   = e;
      configuration_in.param.stride      = st;
      configuration_in.param.granularity = g;
      configuration_in.meta              = meta;
      step();
      configuration_in.valid = 1'b0;
      step();
      check("cfg_err_after_setup", 64'(config_error_out), 64'((inc == dec) || (st == 0)));
      check("quiet_before_start", 64'({u_if.response_out.valid, busy_out, done_out}), 64'(0));
   endtask

   // rmode: 0 ready always, 1 toggling, 2 random. pause_idx < 0 disables the pause window.
   task automatic run_seq(input bit inc, input bit dec, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] st, input logic [31:0] g,
                          input int rmode, input int pause_idx, input bit noise);
      MemoryPacketMeta    meta;
      StrideIndexResponse held;
      StrideIndexResponse acc_beat;
      bit                 held_v;
      bit                 acc;
      bit                 first_seen;
      bit                 pause_used;
      bit                 pause_beat_gone;
      int                 n_got;
      int                 cyc;
      int                 pcnt;
      meta = 10'($urandom);
      build_expected(inc, dec, s, e, st, g);
      load_config(inc, dec, s, e, st, g, meta);
      n_got = 0; cyc = 0; pcnt = 0;
      first_seen = 0; pause_used = 0; pause_beat_gone = 0;
      start_in = 1'b1;
      while (!done_out && cyc < 2000) begin
         case (rmode)
            0:       u_if.response_out_ready = 1'b1;
            1:       u_if.response_out_ready = ((cyc % 2) == 0);
            default: u_if.response_out_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (pcnt > 0) u_if.response_out_ready = (pcnt <= 7);
         if (noise) begin
            configuration_in.valid             = 1'b1;
            configuration_in.param.index_start = $urandom;
            configuration_in.meta              = 10'($urandom);
         end
         acc      = u_if.response_out.valid && u_if.response_out_ready;
         acc_beat = u_if.response_out;
         held_v   = u_if.response_out.valid && !u_if.response_out_ready;
         held     = u_if.response_out;
         step();
         cyc++;
         if (acc) begin
            if (n_got < exp_q.size()) begin
               check("beat_index", 64'(acc_beat.index), 64'(exp_q[n_got].index));
               check("beat_last", 64'(acc_beat.last), 64'(exp_q[n_got].last));
               check("beat_final", 64'(acc_beat.final_beat), 64'(exp_q[n_got].fin));
               check("beat_meta", 64'(acc_beat.meta), 64'(meta));
            end else begin
               check("extra_beat", 64'(acc_beat.index), 64'(32'hDEAD_BEEF));
            end
            n_got++;
            if (acc_beat.final_beat) check("done_after_final", 64'(done_out), 64'(1));
            if (pause_used && acc_beat.index == 32'(pause_idx)) pause_beat_gone = 1;
         end
         if (held_v) check("held_stable", 64'(u_if.response_out), 64'(held));
         if (u_if.response_out.valid && !first_seen) begin
            first_seen = 1;
            check("first_beat_latency", 64'(cyc), 64'(3));
         end
         if (pcnt > 0) begin
            if (pause_beat_gone) check("quiet_in_pause", 64'(u_if.response_out.valid), 64'(0));
            pcnt--;
            if (pcnt == 0) pause_in = 1'b0;
         end
         if (pause_idx >= 0 && !pause_used && u_if.response_out.valid &&
             u_if.response_out.index == 32'(pause_idx)) begin
            pause_used = 1;
            pause_in   = 1'b1;
            pcnt       = 10;
         end
      end
      configuration_in.valid = 1'b0;
      pause_in               = 1'b0;
      check("done_reached", 64'(done_out), 64'(1));
      check("beat_count", 64'(n_got), 64'(exp_q.size()));
      check("not_busy_in_done", 64'(busy_out), 64'(0));
      if (exp_q.size() == 0) check("empty_done_latency", 64'(cyc), 64'(1));
      if (pause_idx >= 0) check("pause_happened", 64'(pause_used), 64'(1));
      step();
      check("done_holds_while_start", 64'(done_out), 64'(1));
      start_in = 1'b0;
      step();
      check("done_clears_to_idle", 64'(done_out), 64'(0));
   endtask

   initial begin
      int          cnt;
      bit          r_inc;
      logic [31:0] base;
      logic [31:0] span;
      logic [31:0] r_s;
      logic [31:0] r_e;

      areset_n                = 1'b0;
      start_in                = 1'b0;
      pause_in                = 1'b0;
      configuration_in        = '0;
      u_if.response_out_ready = 1'b0;
      #12;
      check("reset_outputs", 64'({u_if.response_out.valid, busy_out, done_out, config_error_out}), 64'(0));
      areset_n = 1'b1;
      step();
      check("idle_after_reset", 64'({busy_out, done_out}), 64'(0));

      run_seq(1'b1, 1'b0, 32'd0, 32'd10, 32'd2, 32'd2, 0, -1, 1'b0);
      run_seq(1'b0, 1'b1, 32'd20, 32'd5, 32'd5, 32'd1, 0, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'd0, 32'd10, 32'd2, 32'd2, 1, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'd0, 32'd100, 32'd1, 32'd4, 0, 3, 1'b0);
      run_seq(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'd0, 32'd50, 32'd0, 32'd2, 0, -1, 1'b0);
      run_seq(1'b0, 1'b1, 32'd3, 32'd0, 32'd2, 32'd3, 0, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'd5, 32'd5, 32'd1, 32'd1, 0, -1, 1'b0);
      run_seq(1'b1, 1'b1, 32'd0, 32'd9, 32'd1, 32'd1, 0, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'd0, 32'd20, 32'd1, 32'h0001_0005, 2, -1, 1'b0);
      run_seq(1'b1, 1'b0, 32'd0, 32'd9, 32'd1, 32'd3, 0, -1, 1'b0);

      // Reset with a beat held in the output register.
      load_config(1'b1, 1'b0, 32'd0, 32'd100, 32'd1, 32'd2, '0);
      start_in = 1'b1;
      cnt      = 0;
      while (!u_if.response_out.valid && cnt < 20) begin
         step();
         cnt++;
      end
      step();
      check("beat_held_before_reset", 64'(u_if.response_out.valid), 64'(1));
      #2 areset_n = 1'b0;
      #1;
      check("valid_drops_on_reset", 64'(u_if.response_out.valid), 64'(0));
      check("busy_drops_on_reset", 64'(busy_out), 64'(0));
      start_in = 1'b0;
      step();
      areset_n = 1'b1;
      run_seq(1'b1, 1'b0, 32'd8, 32'd9, 32'd1, 32'd4, 0, -1, 1'b0);

      for (int t = 0; t < 10; t++) begin
         r_inc = 1'($urandom_range(0, 1));
         span  = $urandom_range(1, 60);
         case ($urandom_range(0, 2))
            0:       base = $urandom_range(100, 5000);
            1:       base = 32'hFFFF_FFFF - $urandom_range(0, 40);
            default: base = $urandom_range(0, 40);
         endcase
         if (r_inc) begin
            r_s = base;
            r_e = (base > 32'hFFFF_FF00) ? 32'hFFFF_FFFF : base + span;
         end else begin
            r_s = base;
            r_e = (base > span) ? base - span : 32'd0;
         end
         run_seq(r_inc, !r_inc, r_s, r_e, $urandom_range(1, 7), $urandom_range(0, 5),
                 2, -1, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
